// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl
//  Purpose  : Time-multiplexed scan controller for a multi-digit common-anode
//             7-segment display. One shared hex decoder is fed through
//             hex_out while the active-low anodes select one digit per slot.
//             The displayed value is double-buffered and committed only when
//             the digit index wraps, so a frame never mixes old and new data.
//  Ports    : clk        - system clock, rising edge
//             rst        - asynchronous reset, active-high
//             data_in    - 4*NUM_DIGITS bits, nibble k drives digit k (0 = LSD)
//             load       - 1-cycle strobe, captures data_in into pending buffer
//             digit_en   - per-digit enable, 0 keeps that anode off
//             hex_out    - registered nibble for the segment decoder
//             an         - registered anode drive, active-low (1 = off)
//             frame_done - 1-cycle pulse in the first cycle of a new frame
//  Config   : SEG_LZB_EN - when defined, leading-zero blanking is enabled
//  Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK_CYC  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [3:0]              hex_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int c_CNT_W = $clog2(SCAN_DIV);
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [0:0] c_BLANK = 1'b0;
    localparam logic [0:0] c_SHOW  = 1'b1;

    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_IDX_W-1:0]      r_idx;
    logic [0:0]              r_state;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [4*NUM_DIGITS-1:0] r_pend;
    logic                    r_pend_vld;
    logic [3:0]              r_hex;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_fd;

    logic                    w_slot_end;
    logic                    w_blank_end;
    logic                    w_last_idx;
    logic                    w_wrap;
    logic [c_CNT_W-1:0]      w_cnt_nxt;
    logic [c_IDX_W-1:0]      w_idx_nxt;
    logic [0:0]              w_state_nxt;
    logic [4*NUM_DIGITS-1:0] w_disp_nxt;
    logic [3:0]              w_hex_nxt;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic [NUM_DIGITS-1:0]   w_vis;

    assign w_slot_end  = (r_cnt == c_CNT_W'(SCAN_DIV - 1));
    assign w_blank_end = (r_cnt == c_CNT_W'(BLANK_CYC - 1));
    assign w_last_idx  = (r_idx == c_IDX_W'(NUM_DIGITS - 1));
    assign w_wrap      = w_slot_end & w_last_idx;

    assign w_cnt_nxt = w_slot_end ? '0 : r_cnt + 1'b1;
    assign w_idx_nxt = !w_slot_end ? r_idx : (w_last_idx ? '0 : r_idx + 1'b1);

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == c_BLANK && w_blank_end) begin
            w_state_nxt = c_SHOW;
        end else if (r_state == c_SHOW && w_slot_end) begin
            w_state_nxt = c_BLANK;
        end
    end

    // A load on the wrap edge itself bypasses the pending buffer.
    always_comb begin
        w_disp_nxt = r_disp;
        if (w_wrap) begin
            if (load) begin
                w_disp_nxt = data_in;
            end else if (r_pend_vld) begin
                w_disp_nxt = r_pend;
            end
        end
    end

    // hex_out is loaded from the post-commit display value so digit 0 of a
    // new frame already carries the freshly committed nibble.
    always_comb begin
        w_hex_nxt = 4'h0;
        w_sel     = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_idx_nxt == c_IDX_W'(k)) begin
                w_hex_nxt = w_disp_nxt[4*k +: 4];
                w_sel[k]  = 1'b1;
            end
        end
    end

`ifdef SEG_LZB_EN
    // Digit k (k > 0) is a leading zero when it and every more significant
    // nibble are zero; digit 0 is never blanked.
    logic [NUM_DIGITS-1:0] w_lz;

    always_comb begin
        logic l_run;
        w_lz  = '0;
        l_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            l_run   = l_run & (r_disp[4*k +: 4] == 4'h0);
            w_lz[k] = l_run;
        end
    end

    assign w_vis = digit_en & ~w_lz;
`else
    assign w_vis = digit_en;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_state    <= c_BLANK;
            r_disp     <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_hex      <= 4'h0;
            r_an       <= '1;
            r_fd       <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_state <= w_state_nxt;
            r_disp  <= w_disp_nxt;
            r_hex   <= w_hex_nxt;
            r_fd    <= w_wrap;

            if (w_wrap) begin
                r_pend_vld <= 1'b0;
            end else if (load) begin
                r_pend     <= data_in;
                r_pend_vld <= 1'b1;
            end

            // Anodes follow the state being entered, so they switch on the
            // same edge as the state change.
            if (w_state_nxt == c_SHOW) begin
                r_an <= ~(w_sel & w_vis);
            end else begin
                r_an <= '1;
            end
        end
    end

    assign hex_out    = r_hex;
    assign an         = r_an;
    assign frame_done = r_fd;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_ctrl
//  Purpose  : Self-checking bench for seg_scan_ctrl with NUM_DIGITS=4,
//             SCAN_DIV=8, BLANK_CYC=2 (32-cycle frame). Loads are recorded
//             in a scoreboard tagged with the frame that should show them;
//             entries are retired at each frame boundary and every cycle's
//             an / hex_out / frame_done is compared against the expectation.
//  Config   : SEG_LZB_EN - selects the leading-zero blanking expectations
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int c_ND    = 4;
    localparam int c_DIV   = 8;
    localparam int c_BLANK = 2;
    localparam int c_FRAME = c_ND * c_DIV;

    logic        clk;
    logic        rst;
    logic [15:0] data_in;
    logic        load;
    logic [3:0]  digit_en;
    logic [3:0]  hex_out;
    logic [3:0]  an;
    logic        frame_done;

    typedef struct {
        int          frame;
        logic [15:0] val;
    } sb_t;

    sb_t         sb_q[$];
    logic [15:0] m_disp;
    int          t;
    int          phase;
    int          n_checks;
    int          n_fail;

    seg_scan_ctrl #(
        .NUM_DIGITS (c_ND),
        .SCAN_DIV   (c_DIV),
        .BLANK_CYC  (c_BLANK)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .load       (load),
        .digit_en   (digit_en),
        .hex_out    (hex_out),
        .an         (an),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    // Visible digits: enabled, and (with blanking) digit k>0 only if the value
    // shifted down by k nibbles is non-zero.
    function automatic logic [3:0] vis_of(input logic [15:0] d, input logic [3:0] en);
        logic [3:0] v;
        v = en;
`ifdef SEG_LZB_EN
        for (int k = 1; k < c_ND; k++) begin
            if ((d >> (4 * k)) == 16'h0) v[k] = 1'b0;
        end
`else
        if (d == 16'hFFFF) v = en; // no blanking: every enabled digit shows
`endif
        return v;
    endfunction

    task automatic push_load(input logic [15:0] val);
        sb_t e;
        load    = 1'b1;
        data_in = val;
        e.frame = t / c_FRAME + 1;
        e.val   = val;
        sb_q.push_back(e);
    endtask

    task automatic check_cycle();
        int         pos;
        int         slot;
        logic [3:0] exp_an;
        logic [3:0] exp_hex;
        logic [15:0] shifted;
        if (t > 0 && (t % c_FRAME) == 0) begin
            while (sb_q.size() > 0 && sb_q[0].frame <= t / c_FRAME) begin
                m_disp = sb_q[0].val;
                void'(sb_q.pop_front());
            end
        end
        pos     = t % c_DIV;
        slot    = (t / c_DIV) % c_ND;
        shifted = m_disp >> (4 * slot);
        exp_hex = shifted[3:0];
        if (pos < c_BLANK) begin
            exp_an = 4'hF;
        end else begin
            exp_an = ~(vis_of(m_disp, digit_en) & (4'b0001 << slot));
        end
        check_eq("an", 32'(an), 32'(exp_an));
        check_eq("hex_out", 32'(hex_out), 32'(exp_hex));
        check_eq("frame_done", 32'(frame_done), 32'((t > 0 && (t % c_FRAME) == 0) ? 1 : 0));
    endtask

    task automatic drive_cycle();
        load = 1'b0;
        if (phase == 0) begin
            case (t)
                40:  push_load(16'h1234);
                100: push_load(16'hAAAA);
                110: push_load(16'h5555);
                127: push_load(16'h9999);   // exactly on the wrap edge
                170: push_load(16'hFFFF);
                191: digit_en = 4'b1010;
                223: digit_en = 4'b1111;
                230: push_load(16'h0070);
                290: push_load(16'h0000);
                360: push_load(16'h4321);   // discarded by the mid-frame reset
                default: ;
            endcase
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        phase    = 0;
        t        = 0;
        m_disp   = 16'h0;
        rst      = 1'b1;
        load     = 1'b0;
        data_in  = 16'h0;
        digit_en = 4'hF;

        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_an", 32'(an), 32'h0000000F);
        check_eq("rst_hex", 32'(hex_out), 32'h0);
        check_eq("rst_fd", 32'(frame_done), 32'h0);

        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c <= 371; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            t = c;
            check_cycle();
            drive_cycle();
        end

        // Cycle 371 is a SHOW cycle of digit 2; reset lands mid-slot.
        rst = 1'b1;
        #1;
        check_eq("midrst_an", 32'(an), 32'h0000000F);
        check_eq("midrst_hex", 32'(hex_out), 32'h0);
        check_eq("midrst_fd", 32'(frame_done), 32'h0);

        @(negedge clk);
        sb_q.delete();
        m_disp = 16'h0;
        phase  = 1;
        rst    = 1'b0;
        for (int c = 0; c <= 70; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            t = c;
            check_cycle();
            drive_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
